// File: rtl/if_stage_pkg.sv
// Shared constants for the instruction-fetch stage: bus widths, reset/bubble encodings,
// pause polarity and the IF state encodings.
package if_stage_pkg;

  localparam int INST_W = 16;
  localparam int PC_W   = 16;

  localparam logic PAUSE_ENABLE = 1'b1;

  localparam logic [PC_W-1:0]   PC_RESET_DEF = 16'h0000;
  localparam logic [INST_W-1:0] NOP_INST_DEF = 16'h0800;

  localparam int IF_STATE_W = 2;
  localparam logic [IF_STATE_W-1:0] IF_IDLE  = 2'd0;
  localparam logic [IF_STATE_W-1:0] IF_FETCH = 2'd1;
  localparam logic [IF_STATE_W-1:0] IF_HOLD  = 2'd2;

  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

endpackage

// File: rtl/if_hold_buf.sv
// One-entry instruction/PC buffer that parks a fetch accepted while IF/ID is paused.
// Clear wins over load so a jump in the same cycle always discards the entry.
module if_hold_buf
  import if_stage_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              load_i,
  input  logic              clr_i,
  input  logic [INST_W-1:0] inst_i,
  input  logic [PC_W-1:0]   pc_i,
  output logic [INST_W-1:0] inst_o,
  output logic [PC_W-1:0]   pc_o,
  output logic              valid_o
);

  logic [INST_W-1:0] inst_q, inst_d;
  logic [PC_W-1:0]   pc_q, pc_d;
  logic              valid_q, valid_d;

  always_comb begin
    inst_d  = inst_q;
    pc_d    = pc_q;
    valid_d = valid_q;
    if (clr_i) begin
      valid_d = 1'b0;
    end else if (load_i) begin
      inst_d  = inst_i;
      pc_d    = pc_i;
      valid_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      inst_q  <= '0;
      pc_q    <= '0;
      valid_q <= 1'b0;
    end else begin
      inst_q  <= inst_d;
      pc_q    <= pc_d;
      valid_q <= valid_d;
    end
  end

  assign inst_o  = inst_q;
  assign pc_o    = pc_q;
  assign valid_o = valid_q;

endmodule

// File: rtl/if_stage.sv
// Instruction fetch stage with IF/ID register, pause hold buffer and jump redirect.
// Optional fetch/stall counters are enabled by defining IF_STALL_CNT_EN.
module if_stage
  import if_stage_pkg::*;
#(
  parameter logic [PC_W-1:0]   PC_RESET = PC_RESET_DEF,
  parameter logic [INST_W-1:0] NOP_INST = NOP_INST_DEF
)(
  input  logic              clk_50MHz,
  input  logic              rst,
  input  logic              if_PAUSE,
  input  logic              jump_en,
  input  logic [PC_W-1:0]   jump_addr,
  input  logic              mem_busy,
  output logic              imem_req,
  output logic [PC_W-1:0]   imem_addr,
  input  logic [INST_W-1:0] imem_data,
  input  logic              imem_ready,
  output logic [INST_W-1:0] id_inst,
  output logic [PC_W-1:0]   id_PC,
  output logic              id_valid
`ifdef IF_STALL_CNT_EN
  ,
  output logic [15:0]       fetch_cnt,
  output logic [15:0]       stall_cnt
`endif
);

  logic [IF_STATE_W-1:0] state_q, state_d;
  logic [PC_W-1:0]       pc_q, pc_d;
  logic [INST_W-1:0]     id_inst_q, id_inst_d;
  logic [PC_W-1:0]       id_pc_q, id_pc_d;
  logic                  id_valid_q, id_valid_d;

  logic                  paused;
  logic                  accept;
  logic [PC_W-1:0]       pc_inc;
  logic                  buf_load, buf_clr, buf_valid;
  logic [INST_W-1:0]     buf_inst;
  logic [PC_W-1:0]       buf_pc;

  assign paused    = (if_PAUSE == PAUSE_ENABLE);
  assign pc_inc    = pc_q + 16'd1;
  // Request is masked by reset and jump so an abandoned or squashed fetch never lands.
  assign imem_req  = rst && (state_q == IF_FETCH) && !mem_busy && !jump_en;
  assign imem_addr = pc_q;
  assign accept    = imem_req && imem_ready;

  if_hold_buf u_hold_buf (
    .clk     (clk_50MHz),
    .rst     (rst),
    .load_i  (buf_load),
    .clr_i   (buf_clr),
    .inst_i  (imem_data),
    .pc_i    (pc_inc),
    .inst_o  (buf_inst),
    .pc_o    (buf_pc),
    .valid_o (buf_valid)
  );

  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    id_inst_d  = id_inst_q;
    id_pc_d    = id_pc_q;
    id_valid_d = id_valid_q;
    buf_load   = 1'b0;
    buf_clr    = 1'b0;
    if (jump_en) begin
      pc_d       = jump_addr;
      id_inst_d  = NOP_INST;
      id_valid_d = 1'b0;
      buf_clr    = 1'b1;
      state_d    = IF_FETCH;
    end else begin
      case (state_q)
        IF_IDLE: state_d = IF_FETCH;
        IF_FETCH: begin
          if (accept) begin
            pc_d = pc_inc;
            if (paused) begin
              buf_load = 1'b1;
              state_d  = IF_HOLD;
            end else begin
              id_inst_d  = imem_data;
              id_pc_d    = pc_inc;
              id_valid_d = 1'b1;
            end
          end else if (!paused) begin
            id_inst_d  = NOP_INST;
            id_valid_d = 1'b0;
          end
        end
        IF_HOLD: begin
          if (!paused && buf_valid) begin
            id_inst_d  = buf_inst;
            id_pc_d    = buf_pc;
            id_valid_d = 1'b1;
            buf_clr    = 1'b1;
            state_d    = IF_FETCH;
          end
        end
        default: state_d = IF_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk_50MHz) begin
    if (!rst) begin
      state_q    <= IF_IDLE;
      pc_q       <= PC_RESET;
      id_inst_q  <= NOP_INST;
      id_pc_q    <= 16'h0000;
      id_valid_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      id_inst_q  <= id_inst_d;
      id_pc_q    <= id_pc_d;
      id_valid_q <= id_valid_d;
    end
  end

  assign id_inst  = id_inst_q;
  assign id_PC    = id_pc_q;
  assign id_valid = id_valid_q;

`ifdef IF_STALL_CNT_EN
  logic [15:0] fetch_cnt_q, fetch_cnt_d;
  logic [15:0] stall_cnt_q, stall_cnt_d;
  logic        stall_cycle;

  assign stall_cycle = ((state_q == IF_FETCH) && !accept) || (state_q == IF_HOLD);

  always_comb begin
    fetch_cnt_d = accept ? sat_inc16(fetch_cnt_q) : fetch_cnt_q;
    stall_cnt_d = stall_cycle ? sat_inc16(stall_cnt_q) : stall_cnt_q;
  end

  always_ff @(posedge clk_50MHz) begin
    if (!rst) begin
      fetch_cnt_q <= 16'h0000;
      stall_cnt_q <= 16'h0000;
    end else begin
      fetch_cnt_q <= fetch_cnt_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign fetch_cnt = fetch_cnt_q;
  assign stall_cnt = stall_cnt_q;
`endif

endmodule

// File: tb/tb_if_stage.sv
// Scoreboard bench for if_stage: directed scenarios then random traffic, checked by a
// transaction-level model (pending-fetch queue, PC counter) in the bench.
module tb_if_stage;

  logic        clk_50MHz = 1'b0;
  logic        rst = 1'b0;
  logic        if_PAUSE = 1'b0;
  logic        jump_en = 1'b0;
  logic [15:0] jump_addr = 16'h0000;
  logic        mem_busy = 1'b0;
  logic        imem_req;
  logic [15:0] imem_addr;
  logic [15:0] imem_data;
  logic        imem_ready = 1'b0;
  logic [15:0] id_inst;
  logic [15:0] id_PC;
  logic        id_valid;
`ifdef IF_STALL_CNT_EN
  logic [15:0] fetch_cnt;
  logic [15:0] stall_cnt;
`endif

  always #10 clk_50MHz = ~clk_50MHz;

  function automatic logic [15:0] mem_fn(input logic [15:0] a);
    case (a)
      16'h0000: return 16'h4901;
      16'h0001: return 16'h4902;
      16'h0003: return 16'h6A0F;
      default:  return (a * 16'h9E37) ^ 16'h5A5A;
    endcase
  endfunction

  function automatic logic [15:0] sat16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  assign imem_data = mem_fn(imem_addr);

  if_stage dut (
    .clk_50MHz  (clk_50MHz),
    .rst        (rst),
    .if_PAUSE   (if_PAUSE),
    .jump_en    (jump_en),
    .jump_addr  (jump_addr),
    .mem_busy   (mem_busy),
    .imem_req   (imem_req),
    .imem_addr  (imem_addr),
    .imem_data  (imem_data),
    .imem_ready (imem_ready),
    .id_inst    (id_inst),
    .id_PC      (id_PC),
    .id_valid   (id_valid)
`ifdef IF_STALL_CNT_EN
    ,
    .fetch_cnt  (fetch_cnt),
    .stall_cnt  (stall_cnt)
`endif
  );

  typedef struct packed {
    logic        req;
    logic        chk_addr;
    logic [15:0] addr;
    logic [15:0] inst;
    logic [15:0] pc;
    logic        valid;
    logic [15:0] fcnt;
    logic [15:0] scnt;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;

  // Reference model: a fetch pointer, a queue of fetches parked during a pause,
  // and what the decoder should currently see.
  logic [15:0] m_pc = 16'h0000;
  logic [31:0] m_pend[$];
  logic        m_started = 1'b0;
  logic        m_known = 1'b0;
  logic [15:0] m_inst = 16'h0800;
  logic [15:0] m_idpc = 16'h0000;
  logic        m_valid = 1'b0;
  logic [15:0] m_fc = 16'h0000;
  logic [15:0] m_sc = 16'h0000;

  task automatic drive(input logic r, input logic p, input logic j, input logic [15:0] ja,
                       input logic b, input logic rdy);
    exp_t e;
    logic acc;
    @(negedge clk_50MHz);
    rst = r; if_PAUSE = p; jump_en = j; jump_addr = ja; mem_busy = b; imem_ready = rdy;
    cyc++;
    e.req      = r && m_started && (m_pend.size() == 0) && !b && !j;
    e.chk_addr = m_known;
    e.addr     = m_pc;
    acc        = e.req && rdy;
    if (!r) begin
      m_pc = 16'h0000; m_inst = 16'h0800; m_idpc = 16'h0000; m_valid = 1'b0;
      m_pend.delete(); m_started = 1'b0; m_known = 1'b1; m_fc = 16'h0000; m_sc = 16'h0000;
    end else begin
      if (acc) m_fc = sat16(m_fc);
      if ((m_started && m_pend.size() == 0 && !acc) || m_pend.size() != 0) m_sc = sat16(m_sc);
      if (j) begin
        m_pc = ja; m_inst = 16'h0800; m_valid = 1'b0; m_pend.delete(); m_started = 1'b1;
      end else if (!m_started) begin
        m_started = 1'b1;
      end else if (m_pend.size() != 0) begin
        if (!p) begin
          {m_inst, m_idpc} = m_pend.pop_front();
          m_valid = 1'b1;
        end
      end else if (acc) begin
        if (p) m_pend.push_back({mem_fn(m_pc), m_pc + 16'd1});
        else begin
          m_inst = mem_fn(m_pc); m_idpc = m_pc + 16'd1; m_valid = 1'b1;
        end
        m_pc = m_pc + 16'd1;
      end else if (!p) begin
        m_inst = 16'h0800; m_valid = 1'b0;
      end
    end
    e.inst = m_inst; e.pc = m_idpc; e.valid = m_valid; e.fcnt = m_fc; e.scnt = m_sc;
    exp_q.push_back(e);
  endtask

  // Monitor: samples the combinational request mid-cycle, registered outputs after the edge.
  initial begin
    logic        s_req;
    logic [15:0] s_addr;
    exp_t        e;
    forever begin
      @(negedge clk_50MHz);
      #2;
      s_req  = imem_req;
      s_addr = imem_addr;
      @(posedge clk_50MHz);
      #1;
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        checks++;
        if (s_req !== e.req) begin
          errors++;
          $display("FAIL imem_req cyc=%0d got=%b exp=%b", cyc, s_req, e.req);
        end
        if (e.chk_addr) begin
          checks++;
          if (s_addr !== e.addr) begin
            errors++;
            $display("FAIL imem_addr cyc=%0d got=%h exp=%h", cyc, s_addr, e.addr);
          end
        end
        checks++;
        if (id_valid !== e.valid) begin
          errors++;
          $display("FAIL id_valid cyc=%0d got=%b exp=%b", cyc, id_valid, e.valid);
        end
        checks++;
        if (id_inst !== e.inst) begin
          errors++;
          $display("FAIL id_inst cyc=%0d got=%h exp=%h", cyc, id_inst, e.inst);
        end
        checks++;
        if (id_PC !== e.pc) begin
          errors++;
          $display("FAIL id_PC cyc=%0d got=%h exp=%h", cyc, id_PC, e.pc);
        end
`ifdef IF_STALL_CNT_EN
        checks++;
        if (fetch_cnt !== e.fcnt || stall_cnt !== e.scnt) begin
          errors++;
          $display("FAIL counters cyc=%0d got=%h/%h exp=%h/%h", cyc, fetch_cnt, stall_cnt,
                   e.fcnt, e.scnt);
        end
`endif
        $display("cyc=%0d req=%b addr=%h id_inst=%h id_PC=%h id_valid=%b",
                 cyc, s_req, s_addr, id_inst, id_PC, id_valid);
      end
    end
  end

  initial begin
    int wait_cnt;
    // Reset, then streaming fetch from 0
    drive(0, 0, 0, 16'h0, 0, 1);
    drive(0, 0, 0, 16'h0, 0, 1);
    repeat (4) drive(1, 0, 0, 16'h0, 0, 1);
    // Pause while accepting pc 3, held three more cycles, then release
    repeat (4) drive(1, 1, 0, 16'h0, 0, 1);
    drive(1, 0, 0, 16'h0, 0, 1);
    drive(1, 0, 0, 16'h0, 0, 1);
    // Shared RAM taken by MEM for two cycles at pc 5
    repeat (2) drive(1, 0, 0, 16'h0, 1, 1);
    repeat (2) drive(1, 0, 0, 16'h0, 0, 1);
    // Jump while paused in HOLD discards the buffered fetch
    drive(1, 1, 0, 16'h0, 0, 1);
    drive(1, 1, 1, 16'h0040, 0, 1);
    repeat (2) drive(1, 0, 0, 16'h0, 0, 1);
    // PC wrap at 16'hFFFF
    drive(1, 0, 1, 16'hFFFE, 0, 1);
    repeat (3) drive(1, 0, 0, 16'h0, 0, 1);
    // Reset while a request is outstanding and memory is not ready
    drive(1, 0, 0, 16'h0, 0, 0);
    drive(0, 0, 0, 16'h0, 0, 0);
    repeat (2) drive(1, 0, 0, 16'h0, 0, 1);
    // Random traffic
    for (int i = 0; i < 3000; i++) begin
      logic [15:0] ja;
      ja = ($urandom_range(0, 7) == 0) ? 16'hFFFE : 16'($urandom);
      drive(($urandom_range(0, 63) != 0), ($urandom_range(0, 9) < 3),
            ($urandom_range(0, 19) == 0), ja,
            ($urandom_range(0, 4) == 0), ($urandom_range(0, 9) < 7));
    end
    wait_cnt = 0;
    while (exp_q.size() != 0 && wait_cnt < 20) begin
      @(posedge clk_50MHz);
      wait_cnt++;
    end
    #5;
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain got=%0d exp=0", exp_q.size());
    end
    $display("%0d/%0d checks passed", checks - errors, checks);
    $finish;
  end

endmodule
